// File: rtl/apb_cmd_master.sv
// apb_cmd_master: buffers read/write commands and runs each one as a zero-wait APB SETUP/ACCESS transfer
// Ports: clk, reset (async active-low); cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata command input;
//        rsp_valid/rsp_rdata one-cycle read response; fifo_count/busy status;
//        addr/w_data/r_data/selx/enable/write/read drive and sample the APB_int bus.
module apb_cmd_master #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [7:0]                 cmd_wdata,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       busy,
    output logic [ADDR_W-1:0]          addr,
    output logic [7:0]                 w_data,
    input  logic [7:0]                 r_data,
    output logic                       selx,
    output logic                       enable,
    output logic                       write,
    output logic                       read
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [7:0] mem_wdata [DEPTH];
    logic mem_write [DEPTH];
    logic [PW-1:0] wp, rp;
    logic push, pop;
    // No push-through on full: ready comes only from the registered count.
    assign cmd_ready = fifo_count < CW'(DEPTH);
    assign push = cmd_valid && cmd_ready;
    assign busy = (state != IDLE) || (fifo_count != '0);
    always_comb begin
        state_nx = (state == SETUP) ? ACCESS : ((fifo_count != '0) ? SETUP : IDLE);
        pop = (state_nx == SETUP);
    end
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wp] <= cmd_addr;
            mem_wdata[wp] <= cmd_wdata;
            mem_write[wp] <= cmd_write;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            wp <= '0;
            rp <= '0;
            fifo_count <= '0;
            selx <= 1'b0;
            enable <= 1'b0;
            write <= 1'b0;
            read <= 1'b0;
            addr <= '0;
            w_data <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nx;
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            // Bus outputs are registered from the next state, so they are valid for the whole phase.
            if (state_nx == SETUP) begin
                selx <= 1'b1;
                enable <= 1'b0;
                addr <= mem_addr[rp];
                w_data <= mem_write[rp] ? mem_wdata[rp] : 8'h00;
                write <= mem_write[rp];
                read <= !mem_write[rp];
            end else if (state_nx == ACCESS) begin
                enable <= 1'b1;
            end else begin
                selx <= 1'b0;
                enable <= 1'b0;
                write <= 1'b0;
                read <= 1'b0;
            end
            rsp_valid <= (state == ACCESS) && read;
            if ((state == ACCESS) && read) rsp_rdata <= r_data;
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: scoreboard bench for apb_cmd_master with directed command vectors
module tb_apb_cmd_master;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [2:0]  fifo_count;
    logic        busy;
    logic [31:0] addr;
    logic [7:0]  w_data;
    logic [7:0]  r_data;
    logic        selx;
    logic        enable;
    logic        write;
    logic        read;

    apb_cmd_master #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .fifo_count(fifo_count), .busy(busy),
        .addr(addr), .w_data(w_data), .r_data(r_data), .selx(selx), .enable(enable),
        .write(write), .read(read)
    );

    always #5 clk = ~clk;
    // Bus slave: read data is the low address byte plus 0x18 (0x24 -> 0x3C, 0x04 -> 0x1C).
    assign r_data = addr[7:0] + 8'h18;

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
    } xfer_t;
    xfer_t      exp_bus[$];
    logic [7:0] exp_rsp[$];
    logic [2:0] trace[$];
    logic [2:0] exp_trace[9] = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110, 3'b000};
    xfer_t      mx;
    logic [7:0] mr;
    logic       tr_on = 1'b0;
    int         max_cnt = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [7:0] d, input logic [7:0] rd);
        logic acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = d;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            if (acc) begin
                exp_bus.push_back('{a: a, w: w, d: w ? d : 8'h00});
                if (!w) exp_rsp.push_back(rd);
            end
            #1;
        end
        check("cmd_accepted", acc, 1'b1);
        cmd_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("inv_enable_without_selx", enable && !selx, 1'b0);
            check("inv_read_and_write", read && write, 1'b0);
            check("busy_definition", busy, (fifo_count != 0) || selx);
            if (fifo_count == 3'd4) check("ready_low_when_full", cmd_ready, 1'b0);
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (selx && !enable) begin
                if (exp_bus.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_transfer: got addr %0h, want none", addr);
                end else begin
                    mx = exp_bus.pop_front();
                    check("bus_addr", addr, mx.a);
                    check("bus_write", write, mx.w);
                    check("bus_read", read, !mx.w);
                    check("bus_wdata", w_data, mx.d);
                end
            end
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got %0h, want none", rsp_rdata);
                end else begin
                    mr = exp_rsp.pop_front();
                    check("rsp_rdata", rsp_rdata, mr);
                end
            end
            if (tr_on) trace.push_back({selx, enable, rsp_valid});
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_selx", selx, 1'b0);
        check("rst_enable", enable, 1'b0);
        check("rst_wr_rd", {write, read}, 2'b00);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", w_data, 8'h00);
        check("rst_rsp", {rsp_valid, rsp_rdata}, 9'h000);
        check("rst_count", fifo_count, 3'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rel_ready", cmd_ready, 1'b1);
        check("rel_busy", busy, 1'b0);
        check("rel_selx", selx, 1'b0);
        @(posedge clk);
        #1;
        // Single write
        send(1'b1, 32'h10, 8'hA5, 8'h00);
        @(posedge clk); #1;
        check("w_setup_sel_en", {selx, enable}, 2'b10);
        check("w_setup_addr", addr, 32'h10);
        check("w_setup_wdata", w_data, 8'hA5);
        check("w_setup_wr_rd", {write, read}, 2'b10);
        @(posedge clk); #1;
        check("w_access_sel_en", {selx, enable}, 2'b11);
        check("w_access_addr", addr, 32'h10);
        @(posedge clk); #1;
        check("w_idle_sel_en", {selx, enable}, 2'b00);
        check("w_no_rsp", rsp_valid, 1'b0);
        check("w_idle_busy", busy, 1'b0);
        // Single read, wdata must be forced to 0 on the bus
        send(1'b0, 32'h24, 8'hFF, 8'h3C);
        @(posedge clk); #1;
        check("r_setup", {selx, enable, write, read}, 4'b1001);
        check("r_setup_wdata", w_data, 8'h00);
        @(posedge clk); #1;
        check("r_access", {selx, enable, write, read}, 4'b1101);
        check("r_access_no_rsp_yet", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check("r_rsp_valid", rsp_valid, 1'b1);
        check("r_rsp_data", rsp_rdata, 8'h3C);
        @(posedge clk); #1;
        check("r_rsp_pulse", rsp_valid, 1'b0);
        check("r_rsp_hold", rsp_rdata, 8'h3C);
        check("r_rsp_drained", exp_rsp.size(), 0);
        // Back-to-back W, R, W
        tr_on = 1'b1;
        send(1'b1, 32'h0, 8'h11, 8'h00);
        send(1'b0, 32'h4, 8'h00, 8'h1C);
        send(1'b1, 32'h8, 8'h22, 8'h00);
        repeat (7) @(posedge clk);
        #1 tr_on = 1'b0;
        for (int i = 0; i < 9; i++) check($sformatf("b2b_trace_%0d", i), trace[i], exp_trace[i]);
        check("b2b_rsp_drained", exp_rsp.size(), 0);
        // Full FIFO with pointer wrap-around
        max_cnt = 0;
        for (int i = 0; i < 10; i++) send(1'b1, 32'h100 + 32'(4 * i), 8'(8'h30 + i), 8'h00);
        for (int t = 0; t < 40 && busy; t++) @(posedge clk);
        #1;
        check("full_drain_busy", busy, 1'b0);
        check("full_max_count", max_cnt, 4);
        check("full_all_transfers", exp_bus.size(), 0);
        // Reset during ACCESS with a second command queued
        send(1'b0, 32'h40, 8'h00, 8'h58);
        send(1'b1, 32'h44, 8'h77, 8'h00);
        @(posedge clk); #2;
        check("abort_in_access", {selx, enable}, 2'b11);
        reset = 1'b0;
        #1;
        check("abort_sel_en", {selx, enable}, 2'b00);
        check("abort_count", fifo_count, 3'd0);
        check("abort_rsp", rsp_valid, 1'b0);
        exp_bus.delete();
        exp_rsp.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_idle_busy", busy, 1'b0);
        check("abort_no_rsp", rsp_valid, 1'b0);
        check("end_bus_queue", exp_bus.size(), 0);
        check("end_rsp_queue", exp_rsp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Command-side APB master that sits directly upstream of the bus slaves on the APB_int bus (addr, w_data, r_data, selx, enable, write, read).
- Accepts read/write commands over a valid/ready handshake and buffers them in a small FIFO.
- Sequences each command as an APB SETUP/ACCESS transfer and returns read data on a response strobe.
- Zero-wait-state bus: there is no ready/error signal on the bus, so every transfer takes exactly 2 bus cycles.

Parameters:
- DEPTH, 4, command FIFO depth; must be a power of 2 and at least 2.
- ADDR_W, 32, address width; must match the bus addr width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  8  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse: read data valid.
- rsp_rdata  output  8  read data captured from the bus.
- fifo_count  output  $clog2(DEPTH+1)  number of queued commands.
- busy  output  1  FSM is not in IDLE, or the FIFO is non-empty.
- addr  output  ADDR_W  drives bus addr.
- w_data  output  8  drives bus w_data.
- r_data  input  8  from bus r_data.
- selx  output  1  drives bus selx.
- enable  output  1  drives bus enable.
- write  output  1  drives bus write.
- read  output  1  drives bus read.

Behaviour:
- Reset (asynchronous assert, synchronous release edge):
  - FIFO flushed; fifo_count=0; FSM=IDLE.
  - selx=enable=write=read=0; addr=0; w_data=0; rsp_valid=0; rsp_rdata=0.
  - cmd_ready reads 1 after release.
  - Reset mid-transfer aborts the transfer with no response; queued commands are lost.
- Push:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < DEPTH), taken combinationally from the registered count.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle; there is no push-through-on-full.
- Pop: happens only on the transition into SETUP. Simultaneous push and pop leaves fifo_count unchanged.
- Pointers: log2(DEPTH)-bit read and write pointers that wrap naturally; the count register tracks full/empty.
- FSM states IDLE, SETUP, ACCESS (all outputs registered):
  - IDLE -> SETUP when the FIFO is non-empty. Otherwise stay in IDLE with selx=enable=write=read=0; addr and w_data hold their last values.
  - SETUP (1 cycle): selx=1, enable=0. addr, w_data and write are loaded from the FIFO head; read = ~write. w_data=0 for reads. Always -> ACCESS.
  - ACCESS (1 cycle): selx=1, enable=1; addr, w_data, write and read are held stable. On the closing edge, a read captures r_data into rsp_rdata and asserts rsp_valid for exactly the next cycle.
  - ACCESS -> SETUP if the FIFO is non-empty (back-to-back, selx stays high). Otherwise ACCESS -> IDLE.
- Latency: command accepted at edge k gives:
  - SETUP visible after edge k+1;
  - ACCESS visible after edge k+2;
  - rsp_valid=1 after edge k+3 (reads only).
- Writes produce no response.
- rsp_valid has no backpressure; the consumer must take it in that cycle.
- rsp_rdata holds its value until the next read completes.
- Throughput: one transfer per 2 cycles when the FIFO is kept non-empty.
- busy = (state != IDLE) || (fifo_count != 0).
- Invariants: enable=1 only when selx=1; read and write are never both 1.

Test Plan:
- Reset release → all outputs 0, cmd_ready=1, busy=0. Assert reset while in ACCESS → selx and enable drop immediately (asynchronously); no rsp_valid afterwards.
- Single write: cmd(write=1, addr=0x0000_0010, wdata=0xA5) accepted at edge k → after edge k+1 selx=1, enable=0, addr=0x10, w_data=0xA5, write=1; after k+2 enable=1; after k+3 IDLE, rsp_valid never asserted.
- Single read: cmd(read, addr=0x24) accepted, bus returns r_data=0x3C → read=1 in SETUP and ACCESS; rsp_valid=1 for exactly one cycle with rsp_rdata=0x3C, 3 edges after acceptance.
- Back-to-back: push W(0x0,0x11), R(0x4), W(0x8,0x22) on consecutive cycles → selx stays high throughout; enable toggles 0,1,0,1,0,1; one rsp_valid, in the cycle after the read's ACCESS.
- Full FIFO: hold cmd_valid=1 for 10 cycles with DEPTH=4 → cmd_ready drops when fifo_count=4. No command is lost or duplicated; bus addresses appear in push order, including across pointer wrap-around.
